// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and helpers for the registered N-to-2**N decoder
package decoder_pkg;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } dec_mode_t;

    // State literals carry an S_ prefix because SCAN is already taken by dec_mode_t
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SCAN = 2'd2
    } dec_state_t;

    function automatic int width_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/decoder_n_reg_if.sv
// rtl/decoder_n_reg_if.sv - request/beat handshake bundle between requester and decoder
interface decoder_n_reg_if
    import decoder_pkg::*;
#(
    parameter int N = 3
);
    localparam int W = width_of(N);

    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_sel;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [W-1:0] out_onehot;

    modport master (
        output mode, in_valid, in_sel, out_ready,
        input  in_ready, out_valid, out_onehot, out_last
    );

    modport slave (
        input  mode, in_valid, in_sel, out_ready,
        output in_ready, out_valid, out_onehot, out_last
    );

endinterface

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational enable-gated N-to-2**N one-hot decode
module decoder_onehot #(
    parameter int N = 3
) (
    input  logic                en,
    input  logic [N-1:0]        sel,
    output logic [(1<<N)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_n_reg.sv
// rtl/decoder_n_reg.sv - registered one-hot decoder with DIRECT/SCAN modes; optional DECODER_PARITY_EN request parity check
module decoder_n_reg
    import decoder_pkg::*;
#(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
`ifdef DECODER_PARITY_EN
    input  logic in_par,
    output logic par_err,
`endif
    decoder_n_reg_if.slave bus
);

    localparam logic [N-1:0] ONE = N'(1);

    dec_state_t   state;
    dec_state_t   state_nx;
    logic [N-1:0] cnt;
    logic [N-1:0] start;
    logic         last;
    logic         show;
    logic         ready;
    logic         fire;
    logic         acc;
    logic         par_ok;

`ifdef DECODER_PARITY_EN
    assign par_ok = (in_par == ^bus.in_sel);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A bad-parity request is consumed but never produces a beat
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HOLD: begin
                if (acc) begin
                    if (!par_ok) begin
                        state_nx = S_IDLE;
                    end else if (dec_mode_t'(bus.mode) == SCAN) begin
                        state_nx = S_SCAN;
                    end else begin
                        state_nx = S_HOLD;
                    end
                end else if ((state == S_HOLD) && fire) begin
                    state_nx = S_IDLE;
                end
            end
            S_SCAN: begin
                if (fire && last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The scan wraps after W beats, so the final beat sits one below the start index
    always_comb begin
        last  = 1'b0;
        show  = 1'b0;
        ready = 1'b0;
        case (state)
            S_HOLD:  last = 1'b1;
            S_SCAN:  last = (cnt == (start - ONE));
            default: last = 1'b0;
        endcase
        show  = en & (state != S_IDLE);
        ready = en & ((state == S_IDLE) | ((state == S_HOLD) & bus.out_ready & last));
    end

    assign fire          = show & bus.out_ready;
    assign acc           = ready & bus.in_valid;
    assign bus.in_ready  = ready;
    assign bus.out_valid = show;
    assign bus.out_last  = last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            start <= '0;
        end else if (acc && par_ok) begin
            cnt   <= bus.in_sel;
            start <= bus.in_sel;
        end else if ((state == S_SCAN) && fire && !last) begin
            cnt <= cnt + ONE;
        end
    end

`ifdef DECODER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (acc && !par_ok) begin
            par_err <= 1'b1;
        end
    end
`endif

    decoder_onehot #(
        .N (N)
    ) u_onehot (
        .en     (show),
        .sel    (cnt),
        .onehot (bus.out_onehot)
    );

endmodule
